// File: rtl/udp_payload_packer.sv
// udp_payload_packer: packs measurement words into the UDP transmit RAM and
// requests transmission with the matching UDP/IP length fields once a frame closes.
module udp_payload_packer #(
   parameter int BASE_ADDR = 1,
   parameter int MAX_WORDS = 256,
   parameter int ADDR_W    = 9
) (
   input  logic              e_rxc,
   input  logic              reset,
   input  logic [31:0]       sample_data,
   input  logic              sample_valid,
   input  logic              sample_last,
   output logic              sample_ready,
   input  logic              frame_flush,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [31:0]       ram_wr_data,
   output logic              tx_start,
   input  logic              tx_done,
   output logic [15:0]       tx_data_length,
   output logic [15:0]       tx_total_length,
   output logic              busy
);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] MAXW = ADDR_W'(MAX_WORDS);
   typedef enum logic [1:0] {IDLE, FILL, ARM, WAIT_TX} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d, count_inc;
   logic              ram_wren_q, ram_wren_d;
   logic [ADDR_W-1:0] ram_wr_addr_q, ram_wr_addr_d;
   logic [31:0]       ram_wr_data_q, ram_wr_data_d;
   logic              tx_start_q, tx_start_d;
   logic [15:0]       data_len_q, data_len_d;
   logic [15:0]       total_len_q, total_len_d;
   logic              accept, close;
   always_comb begin
      sample_ready  = !reset && (state_q == IDLE || (state_q == FILL && count_q < MAXW));
      accept        = sample_valid && sample_ready;
      count_inc     = count_q + 1'b1;
      close         = (accept && (sample_last || count_inc == MAXW)) || (frame_flush && state_q == FILL);
      state_d       = state_q;
      count_d       = accept ? count_inc : count_q;
      ram_wren_d    = accept;
      ram_wr_addr_d = accept ? BASE + count_q : ram_wr_addr_q;
      ram_wr_data_d = accept ? sample_data : ram_wr_data_q;
      tx_start_d    = 1'b0;
      data_len_d    = data_len_q;
      total_len_d   = total_len_q;
      case (state_q)
         IDLE, FILL: state_d = close ? ARM : accept ? FILL : state_q;
         ARM: begin
            // The last word's RAM write lands this cycle, so the request follows it.
            tx_start_d  = 1'b1;
            data_len_d  = 16'd8 + (16'(count_q) << 2);
            total_len_d = 16'd28 + (16'(count_q) << 2);
            state_d     = WAIT_TX;
         end
         default: if (tx_done) begin
            state_d       = IDLE;
            count_d       = '0;
            ram_wr_addr_d = BASE;
         end
      endcase
   end
   always_ff @(posedge e_rxc) begin
      if (reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         ram_wren_q    <= 1'b0;
         ram_wr_addr_q <= BASE;
         ram_wr_data_q <= '0;
         tx_start_q    <= 1'b0;
         data_len_q    <= '0;
         total_len_q   <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         ram_wren_q    <= ram_wren_d;
         ram_wr_addr_q <= ram_wr_addr_d;
         ram_wr_data_q <= ram_wr_data_d;
         tx_start_q    <= tx_start_d;
         data_len_q    <= data_len_d;
         total_len_q   <= total_len_d;
      end
   end
   assign ram_wren        = ram_wren_q;
   assign ram_wr_addr     = ram_wr_addr_q;
   assign ram_wr_data     = ram_wr_data_q;
   assign tx_start        = tx_start_q;
   assign tx_data_length  = data_len_q;
   assign tx_total_length = total_len_q;
   assign busy            = state_q != IDLE;
endmodule

// File: tb/tb_udp_payload_packer.sv
// tb_udp_payload_packer: two packers (MAX_WORDS 256 and 4) checked each cycle
// against a frame-level reference model, with directed scenarios then random traffic.
module tb_udp_payload_packer;
   localparam int BASE = 1;
   localparam int MAXW [2] = '{256, 4};
   typedef struct {logic [31:0] w; logic l;} item_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] sdata = '0;
   logic        slast = 1'b0, flush = 1'b0, done = 1'b0;
   logic        valid [2];
   logic        ready [2], wren [2], start [2], busy [2];
   logic [8:0]  addr [2];
   logic [31:0] wdata [2];
   logic [15:0] dlen [2], tlen [2];
   item_t       q [$];
   int          act = 0;
   bit          gap = 0;
   int          checks = 0, errors = 0;
   int          cnt [2], age [2];
   int          e_wren [2], e_addr [2], e_data [2], e_start [2], e_dlen [2], e_tlen [2];
   always #4 clk = ~clk;
   udp_payload_packer #(.BASE_ADDR(1), .MAX_WORDS(256), .ADDR_W(9)) u0 (
      .e_rxc(clk), .reset(rst), .sample_data(sdata), .sample_valid(valid[0]), .sample_last(slast),
      .sample_ready(ready[0]), .frame_flush(flush), .ram_wren(wren[0]), .ram_wr_addr(addr[0]),
      .ram_wr_data(wdata[0]), .tx_start(start[0]), .tx_done(done), .tx_data_length(dlen[0]),
      .tx_total_length(tlen[0]), .busy(busy[0]));
   udp_payload_packer #(.BASE_ADDR(1), .MAX_WORDS(4), .ADDR_W(9)) u1 (
      .e_rxc(clk), .reset(rst), .sample_data(sdata), .sample_valid(valid[1]), .sample_last(slast),
      .sample_ready(ready[1]), .frame_flush(flush), .ram_wren(wren[1]), .ram_wr_addr(addr[1]),
      .ram_wr_data(wdata[1]), .tx_start(start[1]), .tx_done(done), .tx_data_length(dlen[1]),
      .tx_total_length(tlen[1]), .busy(busy[1]));
   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask
   // One clock: drive the source, advance the model, then compare every output.
   task automatic step();
      bit acc;
      int nc;
      valid[0] = 1'b0;
      valid[1] = 1'b0;
      if (q.size() > 0 && !gap) begin
         valid[act] = 1'b1;
         sdata = q[0].w;
         slast = q[0].l;
      end
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            cnt[k] = 0; age[k] = 0; e_wren[k] = 0; e_addr[k] = BASE; e_data[k] = 0;
            e_start[k] = 0; e_dlen[k] = 0; e_tlen[k] = 0;
         end else begin
            acc = valid[k] && age[k] == 0 && cnt[k] < MAXW[k];
            e_wren[k] = int'(acc);
            if (acc) begin
               e_addr[k] = BASE + cnt[k];
               e_data[k] = int'(sdata);
            end
            e_start[k] = int'(age[k] == 1);
            if (age[k] == 1) begin
               e_dlen[k] = 8 + 4 * cnt[k];
               e_tlen[k] = 28 + 4 * cnt[k];
            end
            if (age[k] >= 2 && done) begin
               age[k] = 0; cnt[k] = 0; e_addr[k] = BASE;
            end else if (age[k] >= 1) age[k] = 2;
            else begin
               nc = cnt[k] + int'(acc);
               if ((acc && (slast || nc == MAXW[k])) || (flush && cnt[k] > 0)) age[k] = 1;
               cnt[k] = nc;
            end
            if (acc) void'(q.pop_front());
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("l%0d_ready", k), 32'(ready[k]), 32'(!rst && age[k] == 0 && cnt[k] < MAXW[k]));
         chk($sformatf("l%0d_busy", k), 32'(busy[k]), 32'(cnt[k] != 0));
         chk($sformatf("l%0d_wren", k), 32'(wren[k]), e_wren[k]);
         chk($sformatf("l%0d_addr", k), 32'(addr[k]), e_addr[k]);
         chk($sformatf("l%0d_data", k), wdata[k], e_data[k]);
         chk($sformatf("l%0d_start", k), 32'(start[k]), e_start[k]);
         chk($sformatf("l%0d_dlen", k), 32'(dlen[k]), e_dlen[k]);
         chk($sformatf("l%0d_tlen", k), 32'(tlen[k]), e_tlen[k]);
      end
      flush = 1'b0;
      done = 1'b0;
   endtask
   task automatic push(int n, bit last_at_end);
      for (int i = 0; i < n; i++) q.push_back('{$urandom, last_at_end && i == n - 1});
   endtask
   task automatic wait_tx_start(int k, int dl, int tl);
      int n = 0;
      while (!start[k] && n < 300) begin
         step();
         n++;
      end
      chk($sformatf("l%0d_start_seen", k), 32'(start[k]), 1);
      chk($sformatf("l%0d_len_udp", k), 32'(dlen[k]), dl);
      chk($sformatf("l%0d_len_ip", k), 32'(tlen[k]), tl);
   endtask
   task automatic send_done(int delay);
      repeat (delay) step();
      done = 1'b1;
      step();
   endtask
   initial begin
      valid[0] = 1'b0;
      valid[1] = 1'b0;
      repeat (2) step();
      chk("rst_ready", 32'(ready[0]), 0);
      chk("rst_addr", 32'(addr[0]), 1);
      rst = 1'b0;
      step();
      // Seven-word message closed by sample_last.
      act = 0;
      q.push_back('{32'h48454C4C, 1'b0}); q.push_back('{32'h4F20574F, 1'b0});
      q.push_back('{32'h524C4421, 1'b0}); q.push_back('{32'h0D0A4865, 1'b0});
      q.push_back('{32'h6C6C6F20, 1'b0}); q.push_back('{32'h576F726C, 1'b0});
      q.push_back('{32'h6D20200A, 1'b1});
      wait_tx_start(0, 36, 56);
      send_done(3);
      // Forced close at MAX_WORDS=4; surplus words wait for the next frame.
      act = 1;
      push(6, 0);
      wait_tx_start(1, 24, 44);
      repeat (5) step();
      chk("cap_held", 32'(q.size()), 2);
      chk("cap_ready", 32'(ready[1]), 0);
      send_done(0);
      repeat (4) step();
      flush = 1'b1;
      step();
      wait_tx_start(1, 16, 36);
      send_done(2);
      // Flush of a partial frame, then flush in IDLE.
      act = 0;
      push(3, 0);
      repeat (8) step();
      flush = 1'b1;
      step();
      wait_tx_start(0, 20, 40);
      send_done(1);
      flush = 1'b1;
      step();
      repeat (5) step();
      chk("idle_flush_busy", 32'(busy[0]), 0);
      // Source held off through a long WAIT_TX.
      push(1, 1);
      push(1, 1);
      wait_tx_start(0, 12, 32);
      repeat (100) step();
      chk("wait_held", 32'(q.size()), 1);
      chk("wait_len_stable", 32'(dlen[0]), 12);
      send_done(0);
      wait_tx_start(0, 12, 32);
      send_done(0);
      // Reset in the middle of a frame.
      push(4, 0);
      for (int i = 0; i < 20 && q.size() > 2; i++) step();
      rst = 1'b1;
      step();
      q.delete();
      chk("midrst_busy", 32'(busy[0]), 0);
      chk("midrst_ready", 32'(ready[0]), 0);
      rst = 1'b0;
      push(1, 1);
      wait_tx_start(0, 12, 32);
      send_done(0);
      // Stray tx_done in IDLE and FILL.
      done = 1'b1;
      step();
      chk("stray_idle_busy", 32'(busy[0]), 0);
      push(2, 0);
      repeat (2) step();
      done = 1'b1;
      step();
      chk("stray_fill_busy", 32'(busy[0]), 1);
      flush = 1'b1;
      step();
      wait_tx_start(0, 16, 36);
      send_done(0);
      // Random traffic on both lanes.
      for (int i = 0; i < 3000; i++) begin
         if (q.size() == 0 && $urandom_range(3) == 0) begin
            act = int'($urandom_range(1));
            for (int j = 0; j < int'($urandom_range(10, 1)); j++)
               q.push_back('{$urandom, $urandom_range(5) == 0});
         end
         gap = $urandom_range(3) == 0;
         flush = $urandom_range(24) == 0;
         done = $urandom_range(7) == 0;
         rst = $urandom_range(299) == 0;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
